// File: rtl/simd_mul_pipe_if.sv
// Operand/result bus of the SIMD multiply pipe.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the operand side (in_*) and the result side (out_*).
//
// Signals:
//   in_valid/in_ready  operand handshake
//   in_rs1/2/3         multiplicand, multiplier, accumulator
//   in_mode            lane mode (see simd_mul_pipe)
//   in_op              00 MUL, 01 MULH, 10 MAC, 11 MSU
//   in_rd              destination register address
//   out_valid/out_ready result handshake
//   out_data/out_rd    lane-packed result and its destination register
// master = operand producer / result consumer, slave = the pipe.
interface simd_mul_pipe_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_rs1;
  logic [DATA_W-1:0] in_rs2;
  logic [DATA_W-1:0] in_rs3;
  logic [1:0]        in_mode;
  logic [1:0]        in_op;
  logic [ADDR_W-1:0] in_rd;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_rd;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rs3, in_mode, in_op, in_rd, out_ready,
    input  in_ready, out_valid, out_data, out_rd
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rs3, in_mode, in_op, in_rd, out_ready,
    output in_ready, out_valid, out_data, out_rd
  );
endinterface

// File: rtl/simd_mul_pipe.sv
// Three-stage SIMD multiply / multiply-accumulate unit (4x16, 2x32 or 1x64 signed lanes).
// Latency: 3 cycles from acceptance to out_valid; 1 op/cycle throughput.
// Backpressure: per-stage valid/ready; a stage holds when its successor cannot load, in_ready
//   is derived from out_ready and the stage valid bits only.
//
// Ports:
//   clk, rst  clock, synchronous active-high reset (priority over flush and transfers)
//   flush     drop every in-flight op and any op offered in the same cycle
//   bus       simd_mul_pipe_if.slave: operand handshake in, result handshake out
//   busy      any stage holds a valid op
// Lane modes on in_mode: MODE_16 (2'b00) = 4x16, MODE_32 (2'b01) = 2x32, anything else = 1x64.
module simd_mul_pipe #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  simd_mul_pipe_if.slave  bus,
  output logic            busy
);

  localparam logic [1:0] MODE_16 = 2'b00;
  localparam logic [1:0] MODE_32 = 2'b01;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_MAC  = 2'b10;
  localparam logic [1:0] OP_MSU  = 2'b11;

  localparam int N16 = DATA_W / 16;
  localparam int N32 = DATA_W / 32;
  localparam int PW  = 2 * DATA_W;

  // Control fields that travel alongside the data through every stage.
  typedef struct packed {
    logic [1:0]        mode;
    logic [1:0]        op;
    logic [ADDR_W-1:0] rd;
  } meta_t;

  // Stage registers
  logic              s1_vld, s2_vld, s3_vld;
  meta_t             s1_meta, s2_meta;
  logic [DATA_W-1:0] s1_rs1, s1_rs2, s1_rs3;
  logic [PW-1:0]     s2_prod;   // per-lane full-width products, lane i at [2W*(i+1)-1 : 2W*i]
  logic [DATA_W-1:0] s2_rs3;
  logic [DATA_W-1:0] s3_data;
  logic [ADDR_W-1:0] s3_rd;

  // Advance enables: a stage loads when it is empty or its contents move on this cycle.
  logic s1_ld, s2_ld, s3_ld;

  assign s3_ld = !s3_vld || bus.out_ready;
  assign s2_ld = s3_ld || !s2_vld;
  assign s1_ld = s2_ld || !s1_vld;

  assign bus.in_ready  = s1_ld;
  assign bus.out_valid = s3_vld;
  assign bus.out_data  = s3_data;
  assign bus.out_rd    = s3_rd;
  assign busy          = s1_vld || s2_vld || s3_vld;

  meta_t in_meta;
  assign in_meta = '{mode: bus.in_mode, op: bus.in_op, rd: bus.in_rd};

  // ---------------------------------------------------------------------------
  // S2 datapath: lane products. Operands are sign-extended to the product width
  // so an unsigned multiply truncated to 2W bits yields the signed 2W product.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] prod_c;

  always_comb begin
    prod_c = '0;
    case (s1_meta.mode)
      MODE_16: begin
        for (int i = 0; i < N16; i++) begin
          prod_c[32*i +: 32] = {{16{s1_rs1[16*i+15]}}, s1_rs1[16*i +: 16]}
                             * {{16{s1_rs2[16*i+15]}}, s1_rs2[16*i +: 16]};
        end
      end
      MODE_32: begin
        for (int i = 0; i < N32; i++) begin
          prod_c[64*i +: 64] = {{32{s1_rs1[32*i+31]}}, s1_rs1[32*i +: 32]}
                             * {{32{s1_rs2[32*i+31]}}, s1_rs2[32*i +: 32]};
        end
      end
      default: begin
        prod_c = {{DATA_W{s1_rs1[DATA_W-1]}}, s1_rs1}
               * {{DATA_W{s1_rs2[DATA_W-1]}}, s1_rs2};
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // S3 datapath: per-lane select of low/high half and accumulate. Each lane is
  // computed at its own width, so carries and borrows never cross lanes.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] res_c;

  always_comb begin
    res_c = '0;
    case (s2_meta.mode)
      MODE_16: begin
        for (int i = 0; i < N16; i++) begin
          case (s2_meta.op)
            OP_MUL:  res_c[16*i +: 16] = s2_prod[32*i +: 16];
            OP_MULH: res_c[16*i +: 16] = s2_prod[32*i+16 +: 16];
            OP_MAC:  res_c[16*i +: 16] = s2_rs3[16*i +: 16] + s2_prod[32*i +: 16];
            OP_MSU:  res_c[16*i +: 16] = s2_rs3[16*i +: 16] - s2_prod[32*i +: 16];
            default: res_c[16*i +: 16] = '0;
          endcase
        end
      end
      MODE_32: begin
        for (int i = 0; i < N32; i++) begin
          case (s2_meta.op)
            OP_MUL:  res_c[32*i +: 32] = s2_prod[64*i +: 32];
            OP_MULH: res_c[32*i +: 32] = s2_prod[64*i+32 +: 32];
            OP_MAC:  res_c[32*i +: 32] = s2_rs3[32*i +: 32] + s2_prod[64*i +: 32];
            OP_MSU:  res_c[32*i +: 32] = s2_rs3[32*i +: 32] - s2_prod[64*i +: 32];
            default: res_c[32*i +: 32] = '0;
          endcase
        end
      end
      default: begin
        case (s2_meta.op)
          OP_MUL:  res_c = s2_prod[DATA_W-1:0];
          OP_MULH: res_c = s2_prod[PW-1:DATA_W];
          OP_MAC:  res_c = s2_rs3 + s2_prod[DATA_W-1:0];
          OP_MSU:  res_c = s2_rs3 - s2_prod[DATA_W-1:0];
          default: res_c = '0;
        endcase
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers. Data registers only load when a valid op enters the
  // stage, so a held or bubbled stage keeps its contents. Flush clears only the
  // valid bits; a result taken in the flush cycle has already been consumed.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s2_vld  <= 1'b0;
      s3_vld  <= 1'b0;
      s1_meta <= '0;
      s2_meta <= '0;
      s1_rs1  <= '0;
      s1_rs2  <= '0;
      s1_rs3  <= '0;
      s2_prod <= '0;
      s2_rs3  <= '0;
      s3_data <= '0;
      s3_rd   <= '0;
    end else if (flush) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s3_vld <= 1'b0;
    end else begin
      if (s1_ld) begin
        s1_vld <= bus.in_valid;
        if (bus.in_valid) begin
          s1_meta <= in_meta;
          s1_rs1  <= bus.in_rs1;
          s1_rs2  <= bus.in_rs2;
          s1_rs3  <= bus.in_rs3;
        end
      end
      if (s2_ld) begin
        s2_vld <= s1_vld;
        if (s1_vld) begin
          s2_meta <= s1_meta;
          s2_prod <= prod_c;
          s2_rs3  <= s1_rs3;
        end
      end
      if (s3_ld) begin
        s3_vld <= s2_vld;
        if (s2_vld) begin
          s3_data <= res_c;
          s3_rd   <= s2_meta.rd;
        end
      end
    end
  end

endmodule

// File: tb/tb_simd_mul_pipe.sv
// Directed bench for simd_mul_pipe: lane arithmetic, latency, stall, flush and reset.
// Latency: n/a.
// Backpressure: the bench drives out_ready low for chosen cycles in the stream test.
module tb_simd_mul_pipe;

  localparam logic [1:0] MODE_16 = 2'b00;
  localparam logic [1:0] MODE_32 = 2'b01;
  localparam logic [1:0] MODE_64 = 2'b11;
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULH = 2'b01;
  localparam logic [1:0] OP_MAC  = 2'b10;
  localparam logic [1:0] OP_MSU  = 2'b11;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic busy;

  always #5 clk = ~clk;

  simd_mul_pipe_if #(.DATA_W(64), .ADDR_W(5)) bus ();

  simd_mul_pipe #(.DATA_W(64), .ADDR_W(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus),
    .busy  (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int sent, got, stale;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                        input logic [1:0] mode, input logic [1:0] op, input logic [4:0] rd);
    bus.in_rs1  = a;
    bus.in_rs2  = b;
    bus.in_rs3  = c;
    bus.in_mode = mode;
    bus.in_op   = op;
    bus.in_rd   = rd;
  endtask

  // Single op through an idle pipe with out_ready=1; checks latency, data and rd.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] c, input logic [1:0] mode, input logic [1:0] op,
                        input logic [4:0] rd, input logic [63:0] exp);
    int lat;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    set_op(a, b, c, mode, op, rd);
    #1;
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd3);
    check({tag, "_data"}, bus.out_data, exp);
    check({tag, "_rd"}, 64'(bus.out_rd), 64'(rd));
    @(negedge clk);
    check({tag, "_drained"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_op(64'd0, 64'd0, 64'd0, MODE_64, OP_MUL, 5'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_out_data", bus.out_data, 64'd0);
    check("reset_out_rd", 64'(bus.out_rd), 64'd0);

    // Lane arithmetic
    run_op("mul16", 64'h0003_FFFF_7FFF_0002, 64'h0005_0002_0002_8000, 64'd0,
           MODE_16, OP_MUL, 5'd1, 64'h000F_FFFE_FFFE_0000);
    run_op("mulh32", 64'h8000_0000_0001_0000, 64'h0000_0002_0001_0000, 64'd0,
           MODE_32, OP_MULH, 5'd2, 64'hFFFF_FFFF_0000_0001);
    run_op("mac64", 64'd7, 64'd6, 64'd100, MODE_64, OP_MAC, 5'd3, 64'd142);
    run_op("msu64_rd0", 64'd7, 64'd6, 64'd0, MODE_64, OP_MSU, 5'd0, 64'hFFFF_FFFF_FFFF_FFD6);
    run_op("mac16_wrap", 64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001,
           64'h7FFF_7FFF_7FFF_7FFF, MODE_16, OP_MAC, 5'd4, 64'h8000_8000_8000_8000);
    run_op("mulh64", 64'h8000_0000_0000_0000, 64'd2, 64'd0,
           MODE_64, OP_MULH, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF);
    run_op("msu32_mask", 64'h0000_0000_0000_0003, 64'h0000_0005_0000_0004,
           64'h0000_0010_0000_0001, MODE_32, OP_MSU, 5'd6, 64'h0000_0010_FFFF_FFF5);
    run_op("mulh16", 64'h8000_8000_8000_FFFF, 64'h8000_8000_8000_0003, 64'd0,
           MODE_16, OP_MULH, 5'd7, 64'h4000_4000_4000_FFFF);
    run_op("mode2_is_64", 64'h0000_0001_0000_0001, 64'h0000_0000_0001_0000, 64'd0,
           2'b10, OP_MUL, 5'd8, 64'h0001_0000_0001_0000);

    // Stream of 6 ops (1x64 MUL by 3), out_ready low in cycles 4-6.
    sent = 0;
    got  = 0;
    for (int c = 1; c <= 40 && got < 6; c++) begin
      @(negedge clk);
      bus.out_ready = !(c >= 4 && c <= 6);
      bus.in_valid  = (sent < 6);
      set_op(64'(sent + 1), 64'd3, 64'd0, MODE_64, OP_MUL, 5'(sent + 10));
      #1;
      if (c <= 8)
        check("stream_in_ready", 64'(bus.in_ready), (c >= 4 && c <= 6) ? 64'd0 : 64'd1);
      if (bus.out_valid) begin
        // while stalled this re-checks the same head result each cycle
        check("stream_data", bus.out_data, 64'(3 * (got + 1)));
        check("stream_rd", 64'(bus.out_rd), 64'(got + 10));
        if (bus.out_ready) got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
    end
    bus.in_valid = 1'b0;
    check("stream_count", 64'(got), 64'd6);
    @(negedge clk);
    check("stream_no_dup", 64'(bus.out_valid), 64'd0);
    check("stream_idle", 64'(busy), 64'd0);

    // Flush with three ops in flight and a fourth offered in the flush cycle.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      set_op(64'(k + 20), 64'd2, 64'd0, MODE_64, OP_MUL, 5'(k + 20));
    end
    @(negedge clk);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    set_op(64'd99, 64'd2, 64'd0, MODE_64, OP_MUL, 5'd31);
    #1;
    check("preflush_out_valid", 64'(bus.out_valid), 64'd1);
    check("preflush_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid || busy) stale++;
    end
    check("flush_no_stale", 64'(stale), 64'd0);

    // Reset mid-stream with the pipe full and the output stalled.
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      set_op(64'(k + 5), 64'd5, 64'd0, MODE_64, OP_MUL, 5'(k + 1));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check("prerst_out_data", bus.out_data, 64'd25);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_out_rd", 64'(bus.out_rd), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    run_op("post_rst", 64'hFFFF_FFFF_FFFF_FFFD, 64'd4, 64'd50,
           MODE_64, OP_MAC, 5'd9, 64'd38);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/simd_mul_pipe.md
Name: simd_mul_pipe

Overview:
- Three-stage pipelined SIMD multiply / multiply-accumulate unit in the execute stage.
- Consumes the forwarded, horizontally-permuted and masked operands (Rs1/Rs2/Rs3) produced by the EX hazard/forwarding stage.
- Returns lane-wise products with the destination register address for the EX/MEM register.
- Accepts one operation per cycle with valid/ready backpressure and a pipeline flush.

Parameters:
- DATA_W, 64, operand/result width; equals `SIMD_DATA_WIDTH.
- ADDR_W, 5, register address width; equals `RF_ADDR_WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  kill all in-flight ops (branch/trap redirect)
- in_valid  input  1  operands valid this cycle
- in_ready  output  1  unit can accept an op this cycle
- in_rs1  input  DATA_W  multiplicand (from EXHazard_Rs1Data)
- in_rs2  input  DATA_W  multiplier (from EXHazard_Rs2Data)
- in_rs3  input  DATA_W  accumulator (from EXHazard_Rs3Data)
- in_mode  input  2  lane mode, funct3[1:0]: `SIMD16 = 4x16, `SIMD32 = 2x32, any other value = 1x64
- in_op  input  2  00 MUL (low), 01 MULH (signed high), 10 MAC (rs3+low), 11 MSU (rs3-low)
- in_rd  input  ADDR_W  destination register address
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- out_data  output  DATA_W  lane-packed result
- out_rd  output  ADDR_W  destination register address
- busy  output  1  any stage holds a valid op

Behaviour:
- Stages S1 (operand latch), S2 (lane multiply), S3 (accumulate/select). Each stage has a valid bit, plus mode, op, rd and data registers.
- Latency: an op accepted in cycle N presents out_valid in cycle N+3 when no stall occurs. Throughput is 1 op/cycle.
- Advance rule:
  - S3 may load when it is empty or out_ready=1.
  - S2 may load when S3 may load or S2 is empty.
  - S1 may load when S2 may load or S1 is empty.
  - in_ready = S1 may load. Combinational from out_ready and the valid bits; no combinational path from in_valid.
  - Transfers occur when valid&ready. A held stage keeps all registers unchanged; bubbles may be squeezed out.
- Lane arithmetic (signed two's complement, lane i = bits [W*(i+1)-1 : W*i]):
  - MUL: low W bits of rs1_i*rs2_i.
  - MULH: high W bits of the signed 2W product.
  - MAC: rs3_i + low(rs1_i*rs2_i), wrapping mod 2^W.
  - MSU: rs3_i - low(rs1_i*rs2_i), wrapping mod 2^W.
  - No carry propagates across lane boundaries. 1x64 mode uses a full 128-bit product.
- Masked lanes arrive as zero and need no special handling; a zero lane yields 0 for MUL/MULH and rs3_i for MAC/MSU.
- in_rd = 0: the op is still processed and out_valid still asserts; the register file ignores the write.
- flush: all stage valid bits clear at the next edge. An op presented with in_valid in the flush cycle is also discarded. Data registers may hold stale values.
- flush with out_valid&out_ready in the same cycle: the transfer completes (the consumer already took it), then the pipe is empty.
- rst: all valid bits = 0, out_data = 0, out_rd = 0, out_valid = 0, busy = 0. in_ready = 1 from the first cycle after reset deasserts. rst has priority over flush and transfers.
- busy = S1.valid | S2.valid | S3.valid.
- out_data/out_rd are driven directly from S3 registers and are stable while out_valid=1 and out_ready=0.

Test Plan:
- 4x16 MUL: rs1=0x0003_FFFF_7FFF_0002, rs2=0x0005_0002_0002_8000, mode `SIMD16 -> after 3 cycles out_data=0x000F_FFFE_FFFE_0000.
- 2x32 MULH: rs1=0x8000_0000_0001_0000, rs2=0x0000_0002_0001_0000, mode `SIMD32 -> out_data=0xFFFF_FFFF_0000_0001.
- 1x64 MAC and MSU: rs1=7, rs2=6, rs3=100 -> MAC out_data=142; MSU with rs3=0 -> out_data=0xFFFF_FFFF_FFFF_FFD6.
- Back-to-back stream of 6 ops, out_ready held low cycles 4-6 -> in_ready drops once all 3 stages are full; results emerge in order, none lost or duplicated, out_data stable while stalled.
- flush asserted with 3 ops in flight and in_valid=1 -> next cycle busy=0, out_valid=0, and no stale result appears on any later cycle.
- rst asserted mid-stream for 1 cycle -> out_valid=0, out_data=0, out_rd=0, busy=0 next cycle; a new op afterwards completes with latency 3.
